// File: rtl/rv32i_exec_unit_if.sv
// Request/response bundle between the register-read stage and the RV32I execute unit.
// The execute unit is the slave; the register-read stage is the master.
interface rv32i_exec_unit_if #(
   parameter int ADDR_W = 32
);
   logic              i_start;
   logic [31:0]       i_instr;
   logic [31:0]       i_rs1;
   logic [31:0]       i_rs2;
   logic [ADDR_W-1:0] i_pc;
   logic              o_busy;
   logic              o_done;
   logic              o_wr_en;
   logic [4:0]        o_wr_rd;
   logic [31:0]       o_wr_data;
   logic [ADDR_W-1:0] o_next_pc;
   logic              o_halt;

   modport master (
      output i_start, i_instr, i_rs1, i_rs2, i_pc,
      input  o_busy, o_done, o_wr_en, o_wr_rd, o_wr_data, o_next_pc, o_halt
   );

   modport slave (
      input  i_start, i_instr, i_rs1, i_rs2, i_pc,
      output o_busy, o_done, o_wr_en, o_wr_rd, o_wr_data, o_next_pc, o_halt
   );
endinterface

// File: rtl/rv32i_exec_unit.sv
// RV32I execute/writeback stage: one instruction per start pulse, results on a o_done pulse.
// Shifts are done serially, one bit per cycle, in the writeback data register itself.
module rv32i_exec_unit #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input logic               i_clk,
   input logic               i_rst,
   rv32i_exec_unit_if.slave  bus
);
   localparam logic [6:0] OP_ALUREG = 7'b0110011;
   localparam logic [6:0] OP_ALUIMM = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SHIFT, S_DONE} state_t;

   state_t            state_q;
   logic [31:0]       instr_q;
   logic [XLEN-1:0]   rs1_q, rs2_q;
   logic [ADDR_W-1:0] pc_q;
   logic [4:0]        cnt_q;
   logic              sh_left_q, sh_arith_q;
   logic              done_q, wr_en_q, halt_q;
   logic [4:0]        wr_rd_q;
   logic [XLEN-1:0]   wr_data_q;
   logic [ADDR_W-1:0] next_pc_q;

   logic [6:0]        opcode;
   logic [2:0]        funct3;
   logic [4:0]        rd;
   logic [XLEN-1:0]   imm_i, imm_u, imm_b, imm_j;
   logic [ADDR_W-1:0] pc_plus4;
   logic [XLEN-1:0]   jalr_tgt;
   logic [4:0]        shamt;
   logic              shift_op;
   logic              wr_en_d, halt_d;
   logic [XLEN-1:0]   data_d;
   logic [ADDR_W-1:0] next_pc_d;

   // Non-shift ALU ops; shift funct3 codes pass rs1 through to seed the serial shifter.
   function automatic logic [XLEN-1:0] alu(input logic [2:0] f3, input logic sub,
                                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      logic signed [XLEN-1:0] sa, sb;
      sa = a;
      sb = b;
      case (f3)
         3'b000:  alu = sub ? (a - b) : (a + b);
         3'b010:  alu = XLEN'(sa < sb);
         3'b011:  alu = XLEN'(a < b);
         3'b100:  alu = a ^ b;
         3'b110:  alu = a | b;
         3'b111:  alu = a & b;
         default: alu = a;
      endcase
   endfunction

   function automatic logic br_taken(input logic [2:0] f3,
                                     input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      logic signed [XLEN-1:0] sa, sb;
      sa = a;
      sb = b;
      case (f3)
         3'b000:  br_taken = (a == b);
         3'b001:  br_taken = (a != b);
         3'b100:  br_taken = (sa < sb);
         3'b101:  br_taken = (sa >= sb);
         3'b110:  br_taken = (a < b);
         3'b111:  br_taken = (a >= b);
         default: br_taken = 1'b0;
      endcase
   endfunction

   assign opcode   = instr_q[6:0];
   assign funct3   = instr_q[14:12];
   assign rd       = instr_q[11:7];
   assign imm_i    = {{20{instr_q[31]}}, instr_q[31:20]};
   assign imm_u    = {instr_q[31:12], 12'b0};
   assign imm_b    = {{20{instr_q[31]}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
   assign imm_j    = {{12{instr_q[31]}}, instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
   assign pc_plus4 = pc_q + ADDR_W'(4);
   assign jalr_tgt = (rs1_q + imm_i) & ~XLEN'(1);
   assign shamt    = (opcode == OP_ALUREG) ? rs2_q[4:0] : instr_q[24:20];
   assign shift_op = ((opcode == OP_ALUREG) || (opcode == OP_ALUIMM)) && (funct3[1:0] == 2'b01);

   always_comb begin
      wr_en_d   = 1'b0;
      halt_d    = 1'b0;
      data_d    = '0;
      next_pc_d = pc_plus4;
      case (opcode)
         OP_ALUREG: begin
            wr_en_d = 1'b1;
            data_d  = alu(funct3, instr_q[30], rs1_q, rs2_q);
         end
         OP_ALUIMM: begin
            wr_en_d = 1'b1;
            data_d  = alu(funct3, 1'b0, rs1_q, imm_i);
         end
         OP_LUI: begin
            wr_en_d = 1'b1;
            data_d  = imm_u;
         end
         OP_AUIPC: begin
            wr_en_d = 1'b1;
            data_d  = XLEN'(pc_q) + imm_u;
         end
         OP_JAL: begin
            wr_en_d   = 1'b1;
            data_d    = XLEN'(pc_plus4);
            next_pc_d = pc_q + ADDR_W'(imm_j);
         end
         OP_JALR: begin
            wr_en_d   = 1'b1;
            data_d    = XLEN'(pc_plus4);
            next_pc_d = ADDR_W'(jalr_tgt);
         end
         OP_BRANCH: begin
            if (br_taken(funct3, rs1_q, rs2_q)) next_pc_d = pc_q + ADDR_W'(imm_b);
         end
         OP_SYSTEM: begin
            next_pc_d = pc_q;
            halt_d    = 1'b1;
         end
         default: ;
      endcase
      if (rd == 5'd0) wr_en_d = 1'b0;
   end

   // Operand capture needs no reset: it is only consumed after an accept.
   always_ff @(posedge i_clk) begin
      if (state_q == S_IDLE && bus.i_start) begin
         instr_q <= bus.i_instr;
         rs1_q   <= bus.i_rs1;
         rs2_q   <= bus.i_rs2;
         pc_q    <= bus.i_pc;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         sh_left_q  <= 1'b0;
         sh_arith_q <= 1'b0;
         done_q     <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_rd_q    <= '0;
         wr_data_q  <= '0;
         next_pc_q  <= '0;
         halt_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.i_start) state_q <= S_EXEC;
            end
            S_EXEC: begin
               wr_en_q   <= wr_en_d;
               wr_rd_q   <= rd;
               wr_data_q <= data_d;
               next_pc_q <= next_pc_d;
               if (halt_d) halt_q <= 1'b1;
               if (shift_op && shamt != 5'd0) begin
                  cnt_q      <= shamt;
                  sh_left_q  <= ~funct3[2];
                  sh_arith_q <= funct3[2] & instr_q[30];
                  state_q    <= S_SHIFT;
               end else begin
                  state_q <= S_DONE;
               end
            end
            S_SHIFT: begin
               if (sh_left_q) wr_data_q <= {wr_data_q[XLEN-2:0], 1'b0};
               else           wr_data_q <= {sh_arith_q & wr_data_q[XLEN-1], wr_data_q[XLEN-1:1]};
               cnt_q <= cnt_q - 5'd1;
               if (cnt_q == 5'd1) state_q <= S_DONE;
            end
            S_DONE: begin
               done_q  <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.o_busy    = (state_q != S_IDLE);
   assign bus.o_done    = done_q;
   assign bus.o_wr_en   = wr_en_q;
   assign bus.o_wr_rd   = wr_rd_q;
   assign bus.o_wr_data = wr_data_q;
   assign bus.o_next_pc = next_pc_q;
   assign bus.o_halt    = halt_q;
endmodule
